// File: rtl/bster_axi_ram_if.sv
// rtl/bster_axi_ram_if.sv - AXI4 bundle between the tree engine master and the node RAM slave
// Purpose: groups the five AXI4 channels (AW, W, B, AR, R) of the ram_axi port.
// Ports (signals): aw{id,addr,len,size,burst,lock,cache,prot,valid,ready},
//   w{data,strb,last,valid,ready}, b{id,resp,valid,ready},
//   ar{id,addr,len,size,burst,lock,cache,prot,valid,ready},
//   r{id,data,resp,last,valid,ready}.
// Modports: master (engine side), slave (memory side).
interface bster_axi_ram_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/bster_axi_ram.sv
// rtl/bster_axi_ram.sv - AXI4 slave word RAM holding the binary-tree nodes
// Purpose: synchronous word array behind an AXI4 slave with independent write
//   (W_IDLE/W_DATA/W_RESP) and read (R_IDLE/R_DATA) FSMs; FIXED/INCR bursts,
//   narrow transfers, byte strobes, ID echo, SLVERR on bad burst/size/wlast.
// Ports: aclk - clock; aresetn - async active-low reset;
//   ram_axi - bster_axi_ram_if.slave (AW, W, B, AR, R channels).
// Option: define BSTER_AXI_RAM_RD_REG_EN for a 2-entry R output buffer
//   (2-cycle read latency, rready decoupled from the memory address).
module bster_axi_ram #(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int RAM_STRB_WIDTH = RAM_DATA_WIDTH / 8,
  parameter int RAM_ID_WIDTH   = 8
) (
  input logic            aclk,
  input logic            aresetn,
  bster_axi_ram_if.slave ram_axi
);
  localparam int SB    = $clog2(RAM_STRB_WIDTH);
  localparam int DEPTH = 1 << (RAM_ADDR_WIDTH - SB);

  localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  localparam logic       R_IDLE = 1'b0, R_DATA = 1'b1;

  logic [RAM_DATA_WIDTH-1:0] mem [DEPTH];

  // WRAP (2'b10) and reserved (2'b11) both have burst[1] set.
  function automatic logic cfg_bad(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] || (size > 3'(SB));
  endfunction

  function automatic logic [RAM_ADDR_WIDTH-1:0] next_addr(
      input logic [RAM_ADDR_WIDTH-1:0] addr, input logic [1:0] burst, input logic [2:0] size);
    return (burst == 2'b01) ? addr + (RAM_ADDR_WIDTH'(1) << size) : addr;
  endfunction

  logic unused_sideband;
  assign unused_sideband = ^{ram_axi.awlock, ram_axi.awcache, ram_axi.awprot,
                             ram_axi.arlock, ram_axi.arcache, ram_axi.arprot};

  // ---------------- write path ----------------
  logic [1:0]                w_state;
  logic [RAM_ID_WIDTH-1:0]   w_id;
  logic [RAM_ADDR_WIDTH-1:0] w_addr;
  logic [7:0]                w_len, w_cnt;
  logic [2:0]                w_size;
  logic [1:0]                w_burst;
  logic                      w_sup;  // suppress memory writes for this burst
  logic                      w_err;  // any reason to answer SLVERR

  assign ram_axi.awready = (w_state == W_IDLE);
  assign ram_axi.wready  = (w_state == W_DATA);
  assign ram_axi.bvalid  = (w_state == W_RESP);
  assign ram_axi.bid     = w_id;
  assign ram_axi.bresp   = {w_err, 1'b0};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_sup   <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (ram_axi.awvalid) begin
          w_id    <= ram_axi.awid;
          w_addr  <= ram_axi.awaddr;
          w_len   <= ram_axi.awlen;
          w_size  <= ram_axi.awsize;
          w_burst <= ram_axi.awburst;
          w_cnt   <= '0;
          w_sup   <= cfg_bad(ram_axi.awburst, ram_axi.awsize);
          w_err   <= cfg_bad(ram_axi.awburst, ram_axi.awsize);
          w_state <= W_DATA;
        end
        W_DATA: if (ram_axi.wvalid) begin
          w_addr <= next_addr(w_addr, w_burst, w_size);
          w_cnt  <= w_cnt + 8'd1;
          // The beat count, not wlast, ends the burst; a misplaced wlast only flags SLVERR.
          if (w_cnt == w_len) begin
            w_state <= W_RESP;
            if (!ram_axi.wlast) w_err <= 1'b1;
          end else if (ram_axi.wlast) begin
            w_err <= 1'b1;
          end
        end
        W_RESP: if (ram_axi.bready) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (w_state == W_DATA && ram_axi.wvalid && !w_sup) begin
      for (int b = 0; b < RAM_STRB_WIDTH; b++) begin
        if (ram_axi.wstrb[b])
          mem[w_addr[RAM_ADDR_WIDTH-1:SB]][8*b +: 8] <= ram_axi.wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  logic                      r_state;
  logic [RAM_ADDR_WIDTH-1:0] r_addr, r_next;
  logic [7:0]                r_len, r_cnt;
  logic [2:0]                r_size;
  logic [1:0]                r_burst;
  logic                      r_sup;
  logic [RAM_ID_WIDTH-1:0]   rid_q;
  logic [1:0]                rresp_q;

  assign r_next          = next_addr(r_addr, r_burst, r_size);
  assign ram_axi.arready = (r_state == R_IDLE);
  assign ram_axi.rid     = rid_q;
  assign ram_axi.rresp   = rresp_q;

`ifdef BSTER_AXI_RAM_RD_REG_EN
  // Fetch side fills a 2-entry buffer gated only by its registered fill level,
  // so rready never reaches the memory address. One entry in steady state
  // keeps one beat per cycle.
  logic [RAM_DATA_WIDTH-1:0] buf_data [2];
  logic [1:0]                buf_last, buf_cnt;
  logic                      wr_ptr, rd_ptr, f_act, push, pop;

  assign push           = f_act && (buf_cnt != 2'd2);
  assign pop            = (buf_cnt != 2'd0) && ram_axi.rready;
  assign ram_axi.rvalid = (buf_cnt != 2'd0);
  assign ram_axi.rdata  = buf_data[rd_ptr];
  assign ram_axi.rlast  = ram_axi.rvalid && buf_last[rd_ptr];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      r_addr <= '0; r_len <= '0; r_cnt <= '0; r_size <= '0; r_burst <= '0;
      r_sup <= 1'b0; rid_q <= '0; rresp_q <= '0;
      buf_data[0] <= '0; buf_data[1] <= '0; buf_last <= '0; buf_cnt <= '0;
      wr_ptr <= 1'b0; rd_ptr <= 1'b0; f_act <= 1'b0;
    end else if (r_state == R_IDLE) begin
      if (ram_axi.arvalid) begin
        r_state <= R_DATA;
        r_addr  <= ram_axi.araddr;
        r_len   <= ram_axi.arlen;
        r_size  <= ram_axi.arsize;
        r_burst <= ram_axi.arburst;
        r_cnt   <= '0;
        r_sup   <= cfg_bad(ram_axi.arburst, ram_axi.arsize);
        rresp_q <= cfg_bad(ram_axi.arburst, ram_axi.arsize) ? 2'b10 : 2'b00;
        rid_q   <= ram_axi.arid;
        f_act   <= 1'b1;
      end
    end else begin
      if (push) begin
        buf_data[wr_ptr] <= r_sup ? '0 : mem[r_addr[RAM_ADDR_WIDTH-1:SB]];
        buf_last[wr_ptr] <= (r_cnt == r_len);
        wr_ptr <= ~wr_ptr;
        r_addr <= r_next;
        r_cnt  <= r_cnt + 8'd1;
        if (r_cnt == r_len) f_act <= 1'b0;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (buf_last[rd_ptr]) r_state <= R_IDLE;
      end
      buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
    end
  end
`else
  logic [RAM_DATA_WIDTH-1:0] rdata_q;
  logic                      rvalid_q, rlast_q;

  assign ram_axi.rvalid = rvalid_q;
  assign ram_axi.rdata  = rdata_q;
  assign ram_axi.rlast  = rlast_q;

  // Nonblocking memory reads return pre-write data on a same-word collision.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      r_addr <= '0; r_len <= '0; r_cnt <= '0; r_size <= '0; r_burst <= '0;
      r_sup <= 1'b0; rid_q <= '0; rresp_q <= '0;
      rdata_q <= '0; rvalid_q <= 1'b0; rlast_q <= 1'b0;
    end else if (r_state == R_IDLE) begin
      if (ram_axi.arvalid) begin
        r_state  <= R_DATA;
        r_addr   <= ram_axi.araddr;
        r_len    <= ram_axi.arlen;
        r_size   <= ram_axi.arsize;
        r_burst  <= ram_axi.arburst;
        r_cnt    <= '0;
        r_sup    <= cfg_bad(ram_axi.arburst, ram_axi.arsize);
        rresp_q  <= cfg_bad(ram_axi.arburst, ram_axi.arsize) ? 2'b10 : 2'b00;
        rid_q    <= ram_axi.arid;
        rdata_q  <= cfg_bad(ram_axi.arburst, ram_axi.arsize) ? '0
                    : mem[ram_axi.araddr[RAM_ADDR_WIDTH-1:SB]];
        rvalid_q <= 1'b1;
        rlast_q  <= (ram_axi.arlen == 8'd0);
      end
    end else if (ram_axi.rready) begin
      if (rlast_q) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
        r_state  <= R_IDLE;
      end else begin
        r_addr  <= r_next;
        r_cnt   <= r_cnt + 8'd1;
        rlast_q <= (8'(r_cnt + 8'd1) == r_len);
        rdata_q <= r_sup ? '0 : mem[r_next[RAM_ADDR_WIDTH-1:SB]];
      end
    end
  end
`endif
endmodule

// File: tb/tb_bster_axi_ram.sv
// tb/tb_bster_axi_ram.sv - directed self-checking bench for bster_axi_ram
module tb_bster_axi_ram;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  bster_axi_ram_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(8)) ram_axi ();

  bster_axi_ram #(.RAM_DATA_WIDTH(32), .RAM_ADDR_WIDTH(16), .RAM_STRB_WIDTH(4), .RAM_ID_WIDTH(8))
    dut (.aclk(aclk), .aresetn(aresetn), .ram_axi(ram_axi));

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    ram_axi.awid = id; ram_axi.awaddr = addr; ram_axi.awlen = len;
    ram_axi.awsize = size; ram_axi.awburst = burst; ram_axi.awvalid = 1'b1;
    while (!ram_axi.awready && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) chk("aw_timeout", ram_axi.awready, 1);
    @(posedge aclk); #1;
    ram_axi.awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    ram_axi.wdata = data; ram_axi.wstrb = strb; ram_axi.wlast = last; ram_axi.wvalid = 1'b1;
    while (!ram_axi.wready && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) chk("w_timeout", ram_axi.wready, 1);
    @(posedge aclk); #1;
    ram_axi.wvalid = 1'b0;
  endtask

  task automatic b_get(input string tag, input logic [7:0] id, input logic [1:0] resp);
    int n = 0;
    ram_axi.bready = 1'b1;
    while (!ram_axi.bvalid && n < 50) begin @(posedge aclk); #1; n++; end
    chk({tag, "_bvalid"}, ram_axi.bvalid, 1);
    chk({tag, "_bid"}, ram_axi.bid, id);
    chk({tag, "_bresp"}, ram_axi.bresp, resp);
    @(posedge aclk); #1;
    ram_axi.bready = 1'b0;
  endtask

  task automatic ar_send(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    ram_axi.arid = id; ram_axi.araddr = addr; ram_axi.arlen = len;
    ram_axi.arsize = size; ram_axi.arburst = burst; ram_axi.arvalid = 1'b1;
    while (!ram_axi.arready && n < 50) begin @(posedge aclk); #1; n++; end
    if (n >= 50) chk("ar_timeout", ram_axi.arready, 1);
    @(posedge aclk); #1;
    ram_axi.arvalid = 1'b0;
  endtask

  task automatic r_get(input string tag, input logic [31:0] data, input logic last,
                       input logic [1:0] resp);
    int n = 0;
    ram_axi.rready = 1'b1;
    while (!ram_axi.rvalid && n < 50) begin @(posedge aclk); #1; n++; end
    chk({tag, "_rvalid"}, ram_axi.rvalid, 1);
    chk({tag, "_rdata"}, ram_axi.rdata, data);
    chk({tag, "_rlast"}, ram_axi.rlast, last);
    chk({tag, "_rresp"}, ram_axi.rresp, resp);
    @(posedge aclk); #1;
    ram_axi.rready = 1'b0;
  endtask

  task automatic read1(input string tag, input logic [15:0] addr, input logic [31:0] data);
    ar_send(8'h33, addr, 8'd0, 3'd2, 2'b01);
    r_get(tag, data, 1'b1, 2'b00);
  endtask

  initial begin
    ram_axi.awid = '0; ram_axi.awaddr = '0; ram_axi.awlen = '0; ram_axi.awsize = '0;
    ram_axi.awburst = '0; ram_axi.awlock = '0; ram_axi.awcache = '0; ram_axi.awprot = '0;
    ram_axi.awvalid = 1'b0;
    ram_axi.wdata = '0; ram_axi.wstrb = '0; ram_axi.wlast = 1'b0; ram_axi.wvalid = 1'b0;
    ram_axi.bready = 1'b0;
    ram_axi.arid = '0; ram_axi.araddr = '0; ram_axi.arlen = '0; ram_axi.arsize = '0;
    ram_axi.arburst = '0; ram_axi.arlock = '0; ram_axi.arcache = '0; ram_axi.arprot = '0;
    ram_axi.arvalid = 1'b0; ram_axi.rready = 1'b0;

    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awready", ram_axi.awready, 1);
    chk("rst_arready", ram_axi.arready, 1);
    chk("rst_wready", ram_axi.wready, 0);
    chk("rst_bvalid", ram_axi.bvalid, 0);
    chk("rst_rvalid", ram_axi.rvalid, 0);
    chk("rst_rlast", ram_axi.rlast, 0);
    chk("rst_bid", ram_axi.bid, 0);
    chk("rst_rid", ram_axi.rid, 0);
    chk("rst_bresp", ram_axi.bresp, 0);
    chk("rst_rresp", ram_axi.rresp, 0);
    chk("rst_rdata", ram_axi.rdata, 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Single write then read with latency check
    aw_send(8'h5A, 16'h0010, 8'd0, 3'd2, 2'b01);
    w_beat(32'hDEADBEEF, 4'hF, 1'b1);
    b_get("single", 8'h5A, 2'b00);
    ram_axi.arid = 8'hC3; ram_axi.araddr = 16'h0010; ram_axi.arlen = 8'd0;
    ram_axi.arsize = 3'd2; ram_axi.arburst = 2'b01; ram_axi.arvalid = 1'b1;
    chk("single_arready", ram_axi.arready, 1);
    chk("single_rvalid_pre", ram_axi.rvalid, 0);
    @(posedge aclk); #1;
    ram_axi.arvalid = 1'b0;
    chk("single_lat_rvalid", ram_axi.rvalid, 1);
    chk("single_rid", ram_axi.rid, 8'hC3);
    r_get("single", 32'hDEADBEEF, 1'b1, 2'b00);
    chk("single_rvalid_post", ram_axi.rvalid, 0);

    // INCR burst, read back with rready toggling
    aw_send(8'h01, 16'h0100, 8'd3, 3'd2, 2'b01);
    w_beat(32'd1, 4'hF, 1'b0);
    w_beat(32'd2, 4'hF, 1'b0);
    w_beat(32'd3, 4'hF, 1'b0);
    w_beat(32'd4, 4'hF, 1'b1);
    b_get("incr", 8'h01, 2'b00);
    ar_send(8'h02, 16'h0100, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      ram_axi.rready = 1'b0;
      chk("incr_pre_data", ram_axi.rdata, 32'(i + 1));
      @(posedge aclk); #1;
      chk("incr_stall_valid", ram_axi.rvalid, 1);
      chk("incr_stall_data", ram_axi.rdata, 32'(i + 1));
      chk("incr_stall_last", ram_axi.rlast, (i == 3));
      ram_axi.rready = 1'b1;
      @(posedge aclk); #1;
    end
    ram_axi.rready = 1'b0;
    chk("incr_done_rvalid", ram_axi.rvalid, 0);

    // Strobes and FIXED burst
    aw_send(8'h03, 16'h0020, 8'd0, 3'd2, 2'b01);
    w_beat(32'hAABBCCDD, 4'hF, 1'b1);
    b_get("strb0", 8'h03, 2'b00);
    aw_send(8'h04, 16'h0020, 8'd1, 3'd2, 2'b00);
    w_beat(32'h11111111, 4'h1, 1'b0);
    w_beat(32'h22222222, 4'h8, 1'b1);
    b_get("fixed", 8'h04, 2'b00);
    read1("fixed_rd", 16'h0020, 32'h22BBCC11);

    // WRAP write is answered SLVERR and leaves memory untouched
    aw_send(8'h05, 16'h0020, 8'd1, 3'd2, 2'b10);
    w_beat(32'hFFFFFFFF, 4'hF, 1'b0);
    w_beat(32'hFFFFFFFF, 4'hF, 1'b1);
    b_get("wrap", 8'h05, 2'b10);
    read1("wrap_rd", 16'h0020, 32'h22BBCC11);

    // Early wlast: burst still runs 3 beats, SLVERR
    aw_send(8'h06, 16'h0200, 8'd2, 3'd2, 2'b01);
    w_beat(32'hA, 4'hF, 1'b0);
    w_beat(32'hB, 4'hF, 1'b1);
    chk("early_wready_beat2", ram_axi.wready, 1);
    w_beat(32'hC, 4'hF, 1'b0);
    b_get("early", 8'h06, 2'b10);

    // Oversize read: 2 beats, SLVERR, zero data
    ar_send(8'h07, 16'h0100, 8'd1, 3'd3, 2'b01);
    r_get("oversz0", 32'h0, 1'b0, 2'b10);
    r_get("oversz1", 32'h0, 1'b1, 2'b10);

    // INCR crossing the top of memory lands in word 0
    aw_send(8'h08, 16'hFFFC, 8'd1, 3'd2, 2'b01);
    w_beat(32'h00001234, 4'hF, 1'b0);
    w_beat(32'h00005678, 4'hF, 1'b1);
    b_get("topwrap", 8'h08, 2'b00);
    read1("topwrap_hi", 16'hFFFC, 32'h00001234);
    read1("topwrap_lo", 16'h0000, 32'h00005678);

    // Read completes while a write burst is open
    aw_send(8'h09, 16'h0300, 8'd1, 3'd2, 2'b01);
    w_beat(32'h0000BEEF, 4'hF, 1'b0);
    chk("conc_awready", ram_axi.awready, 0);
    read1("conc_rd", 16'h0104, 32'd2);
    chk("conc_wready", ram_axi.wready, 1);
    w_beat(32'h0000CAFE, 4'hF, 1'b1);
    b_get("conc", 8'h09, 2'b00);
    read1("conc_rd2", 16'h0304, 32'h0000CAFE);

    // Reset in the middle of beat 2 of 4
    aw_send(8'h0A, 16'h0400, 8'd3, 3'd2, 2'b01);
    w_beat(32'h000000A0, 4'hF, 1'b0);
    w_beat(32'h000000A1, 4'hF, 1'b0);
    ram_axi.wdata = 32'h000000A2; ram_axi.wstrb = 4'hF; ram_axi.wlast = 1'b0;
    ram_axi.wvalid = 1'b1;
    #2;
    aresetn = 1'b0;
    #1;
    chk("mrst_awready", ram_axi.awready, 1);
    chk("mrst_wready", ram_axi.wready, 0);
    chk("mrst_bvalid", ram_axi.bvalid, 0);
    chk("mrst_rvalid", ram_axi.rvalid, 0);
    @(posedge aclk); #1;
    ram_axi.wvalid = 1'b0;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("mrst_bvalid_after", ram_axi.bvalid, 0);
    read1("mrst_b0", 16'h0400, 32'h000000A0);
    read1("mrst_b1", 16'h0404, 32'h000000A1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bster_axi_ram.md
Name: bster_axi_ram

Overview:
- AXI4 slave memory that holds the binary-tree nodes; it answers the tree engine's ram_axi_* master port.
- Instantiated next to the engine in the top level and in the engine's testbench.
- Contains an internal synchronous word array with independent write and read channel FSMs, so one write burst and one read burst can be in flight at the same time.
- Supports FIXED and INCR bursts, narrow transfers, per-byte strobes and ID echo.

Parameters:
- RAM_DATA_WIDTH, 32, data bus width in bits (power of 2, 8 or more).
- RAM_ADDR_WIDTH, 16, byte address width; memory depth is 2^(RAM_ADDR_WIDTH-log2(RAM_STRB_WIDTH)) words.
- RAM_STRB_WIDTH, RAM_DATA_WIDTH/8, strobe width.
- RAM_ID_WIDTH, 8, AXI ID width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous assert, active-low.
- ram_axi_awid/awaddr/awlen/awsize/awburst  in  ID/ADDR/8/3/2  write address channel.
- ram_axi_awlock/awcache/awprot  in  1/4/3  accepted and ignored.
- ram_axi_awvalid  in  1; ram_axi_awready  out  1.
- ram_axi_wdata/wstrb/wlast/wvalid  in  DATA/STRB/1/1; ram_axi_wready  out  1.
- ram_axi_bid/bresp/bvalid  out  ID/2/1; ram_axi_bready  in  1.
- ram_axi_arid/araddr/arlen/arsize/arburst  in  ID/ADDR/8/3/2  read address channel.
- ram_axi_arlock/arcache/arprot  in  1/4/3  accepted and ignored.
- ram_axi_arvalid  in  1; ram_axi_arready  out  1.
- ram_axi_rid/rdata/rresp/rlast/rvalid  out  ID/DATA/2/1/1; ram_axi_rready  in  1.

Behaviour:
- Clocking and reset: one clock aclk; aresetn is asynchronous and active-low.
- Reset values: all FSMs go to IDLE; awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0; bid, rid, bresp, rresp and rdata are 0. Memory contents are not reset.
- Reset mid-burst: the burst is abandoned. Beats already written stay in memory; no B or R response is issued.
- Write FSM states: W_IDLE, W_DATA, W_RESP.
  - W_IDLE (awready=1): on AW handshake, latch id, addr, len, size and burst, clear the beat counter and the error flag, then go to W_DATA. awready=0 outside W_IDLE.
  - W_DATA (wready=1): every W handshake writes the bytes enabled by wstrb into the word at addr[ADDR-1:log2(STRB)].
  - INCR: addr += 2^size after each beat. FIXED: addr holds.
  - When the beat counter equals len, go to W_RESP.
  - W_RESP (bvalid=1, bid=latched id): hold until bready, then go to W_IDLE. The earliest next AW acceptance is the cycle after the B handshake.
- Write error rules (bresp=SLVERR 2'b10, otherwise OKAY 2'b00):
  - burst=WRAP or reserved, or size>log2(STRB): all beats are still accepted, but memory writes are suppressed.
  - wlast=1 before the final beat, or wlast=0 on the final beat: the burst still ends on the beat count.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE (arready=1): on AR handshake, latch the read parameters and read mem[addr] synchronously. rvalid rises on the next cycle, giving 1-cycle latency.
  - R_DATA: rdata, rid, rresp and rlast are held stable while rvalid=1 and rready=0.
  - On an R handshake that is not the last beat, advance addr and read the next word in the same cycle. Back-to-back beats run at full throughput, one per cycle.
  - rlast=1 on beat len. After its handshake, go to R_IDLE with rvalid=0.
- Read error rule: burst=WRAP or reserved, or size>log2(STRB) → every beat carries rresp=SLVERR and rdata=0, still len+1 beats.
- Address arithmetic: word index wraps modulo depth, so an INCR burst crossing the top of memory continues at word 0. The 4KB boundary is not checked.
- Write/read collision: same word written and read in the same cycle → the read returns the old data (read-before-write).
- Channel independence: the AW/W and AR/R paths share no stall condition. W beats presented before the AW handshake are not accepted.

Optional Feature:
- Macro: BSTER_AXI_RAM_RD_REG_EN.
- When defined: adds a 2-entry output buffer on the R channel.
  - Read latency is 2 cycles (AR handshake to first rvalid).
  - The memory fetch is decoupled from rready, so full throughput is kept and rready is never a combinational path into the memory address.
- When undefined: 1-cycle latency as described in Behaviour.

Test Plan:
- Single write then read: AW addr=0x0010, len=0, size=2, INCR, wdata=0xDEADBEEF, wstrb=0xF; then AR at the same address → bresp=0, bid echoes awid; rdata=0xDEADBEEF, rlast=1, rvalid exactly 1 cycle after AR handshake.
- INCR burst: write len=3 at 0x0100 with data 1,2,3,4; read it back with rready toggled every cycle → data 1,2,3,4 in order, held stable while stalled, rlast only on the 4th beat.
- Strobes and FIXED: write 0xAABBCCDD to 0x0020, then FIXED len=1 writes of 0x11111111 (wstrb=0x1) and 0x22222222 (wstrb=0x8) → readback 0x22BBCC11.
- Errors: WRAP burst write len=1 → bresp=2'b10 and memory unchanged; write len=2 with wlast on beat 1 → bresp=2'b10 after 3 beats; read size=3 on a 32-bit bus → 1+len beats with rresp=2'b10 and rdata=0.
- Wrap-around and concurrency: INCR write len=1 at the last word → second beat lands in word 0; the read channel returns correct data concurrently with an open write burst.
- Reset mid-burst: drop aresetn during W beat 2 of 4 → awready=1, bvalid=0, rvalid=0 immediately; beats 0-1 persist in memory.
